// File: rtl/inv3_lut_fifo_if.sv
// rtl/inv3_lut_fifo_if.sv - operand/result valid-ready handshake bundle for inv3_lut_fifo
interface inv3_lut_fifo_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X1;
  logic [WIDTH-1:0] X2;
  logic [WIDTH-1:0] X3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y1;

  // Producer/consumer side of the unit
  modport master (
    output in_valid, X1, X2, X3, out_ready,
    input  in_ready, out_valid, Y1
  );

  // The LUT FIFO itself
  modport slave (
    input  in_valid, X1, X2, X3, out_ready,
    output in_ready, out_valid, Y1
  );
endinterface

// File: rtl/inv3_lut_fifo.sv
// rtl/inv3_lut_fifo.sv - bitwise programmable 3-input LUT feeding a DEPTH-entry result FIFO (option: INV3_PARITY_EN)
module inv3_lut_fifo #(
  parameter int         WIDTH    = 8,
  parameter int         DEPTH    = 4,
  parameter logic [7:0] TT_RESET = 8'h01
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [7:0]                   cfg_tt,
  output logic [7:0]                   tt_q,
  inv3_lut_fifo_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef INV3_PARITY_EN
  ,
  output logic                         Y1_par
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]       tt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] res;
  logic             push;
  logic             pop;

  // Ready/valid come from registered occupancy only, so there is no
  // combinational path from out_ready to in_ready or in_valid to out_valid.
  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != CW'(0));
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.Y1        = mem[rd_ptr];
  assign tt_q          = tt;

  // Per-bit table lookup, index is {x3,x2,x1}
  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = tt[{bus.X3[i], bus.X2[i], bus.X1[i]}];
    end
  end

  // Result storage, written on push, deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= res;
    end
  end

`ifdef INV3_PARITY_EN
  logic mem_par [DEPTH];

  // Parity of each pushed result, stored alongside it and unreset like the data
  always_ff @(posedge clk) begin
    if (push) begin
      mem_par[wr_ptr] <= ^res;
    end
  end

  assign Y1_par = mem_par[rd_ptr];
`endif

  // Truth table; a push on the same edge already latched the old table's result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt <= TT_RESET;
    end else if (cfg_we) begin
      tt <= cfg_tt;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inv3_lut_fifo.sv
// tb/tb_inv3_lut_fifo.sv - self-checking bench for inv3_lut_fifo with queue reference model (option: INV3_PARITY_EN)
module tb_inv3_lut_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [7:0]    cfg_tt;
  logic [7:0]    tt_q;
  logic [CW-1:0] count;
`ifdef INV3_PARITY_EN
  logic          Y1_par;
`endif

  inv3_lut_fifo_if #(.WIDTH(WIDTH)) bus ();

  inv3_lut_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TT_RESET(8'h01)) dut (
    .clk    (clk),
    .rst    (rst),
    .cfg_we (cfg_we),
    .cfg_tt (cfg_tt),
    .tt_q   (tt_q),
    .bus    (bus),
    .count  (count)
`ifdef INV3_PARITY_EN
    ,
    .Y1_par (Y1_par)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each result bit is bit number (4*x3 + 2*x2 + x1) of the table
  function automatic logic [7:0] lut(input logic [7:0] t, input logic [7:0] a,
                                     input logic [7:0] b, input logic [7:0] c);
    logic [7:0] y;
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx  = 4 * int'(c[i]) + 2 * int'(b[i]) + int'(a[i]);
      y[i] = (t >> idx) & 8'h01;
    end
    return y;
  endfunction

  logic [7:0] mq[$];
  logic [7:0] mtt = 8'h01;
  bit         started = 0;
  bit         m_push;
  bit         m_pop;
  logic [7:0] m_res;

  // Model: FIFO as a queue, updated on each clock edge or asynchronously on reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mtt     = 8'h01;
      started = 1;
    end else begin
      m_push = bus.in_valid && (mq.size() < DEPTH);
      m_pop  = bus.out_ready && (mq.size() > 0);
      m_res  = lut(mtt, bus.X1, bus.X2, bus.X3);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_res);
      if (cfg_we) mtt = cfg_tt;
    end
  end

  // Compare DUT against model every falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("tt_q", 32'(tt_q), 32'(mtt));
      if (mq.size() > 0) begin
        chk("Y1", 32'(bus.Y1), 32'(mq[0]));
`ifdef INV3_PARITY_EN
        chk("Y1_par", 32'(Y1_par), 32'(^mq[0]));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cfg_we        = 1'b0;
  endtask

  task automatic drain();
    idle();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cfg_tt = 8'h00;
    bus.X1 = '0; bus.X2 = '0; bus.X3 = '0;
    repeat (2) step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tt_q", 32'(tt_q), 32'h01);
    rst = 1'b0;

    // Default NOR table
    bus.in_valid = 1'b1;
    bus.X1 = 8'h0F; bus.X2 = 8'h33; bus.X3 = 8'h55;
    step();
    idle();
    chk("nor_out_valid", 32'(bus.out_valid), 32'd1);
    chk("nor_Y1", 32'(bus.Y1), 32'h80);
    chk("nor_count", 32'(count), 32'd1);
    bus.out_ready = 1'b1;
    step();
    idle();

    // Table change coincident with a push uses the old table
    cfg_we = 1'b1; cfg_tt = 8'h96;
    bus.in_valid = 1'b1;
    bus.X1 = 8'hFF; bus.X2 = 8'h00; bus.X3 = 8'h00;
    step();
    cfg_we = 1'b0;
    chk("cfg_old_Y1", 32'(bus.Y1), 32'h00);
    chk("cfg_tt_q", 32'(tt_q), 32'h96);
    step();
    idle();
    chk("cfg_count", 32'(count), 32'd2);
    bus.out_ready = 1'b1;
    step();
    idle();
    chk("cfg_new_Y1", 32'(bus.Y1), 32'hFF);
    drain();

    // Identity table on X1 to make ordering visible
    cfg_we = 1'b1; cfg_tt = 8'hAA;
    step();
    cfg_we = 1'b0;

    // Fill to full with out_ready low
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.X1 = 8'h10 + 8'(k);
      step();
      chk("fill_count", 32'(count), 32'(k < 4 ? k + 1 : 4));
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("full_pop_Y1", 32'(bus.Y1), 32'h11);
    step();
    idle();
    chk("refill_count", 32'(count), 32'd4);
    drain();

    // Streaming across pointer wrap with occupancy held at one
    bus.in_valid = 1'b1;
    bus.X1 = 8'h40;
    step();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      bus.X1 = 8'h40 + 8'(i);
      step();
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_Y1", 32'(bus.Y1), 32'(8'h40 + 8'(i)));
    end
    drain();

`ifdef INV3_PARITY_EN
    bus.in_valid = 1'b1;
    bus.X1 = 8'h07;
    step();
    bus.X1 = 8'h03;
    step();
    idle();
    chk("par_07", 32'(Y1_par), 32'd1);
    bus.out_ready = 1'b1;
    step();
    idle();
    chk("par_03", 32'(Y1_par), 32'd0);
    drain();
`endif

    // Asynchronous reset with three entries queued
    bus.in_valid = 1'b1;
    repeat (3) begin
      bus.X1 = 8'($urandom);
      step();
    end
    idle();
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_tt_q", 32'(tt_q), 32'h01);
    step();
    rst = 1'b0;

    // Randomized traffic with occasional table loads and resets
    for (int n = 0; n < 600; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cfg_we        = ($urandom_range(0, 15) == 0);
      cfg_tt        = 8'($urandom);
      bus.X1        = 8'($urandom);
      bus.X2        = 8'($urandom);
      bus.X3        = 8'($urandom);
      if (n % 150 == 75) bus.out_ready = 1'b0;
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inv3_lut_fifo.md
# inv3_lut_fifo

Parametrised successor to the single-bit registered inverter stage. It applies a programmable 3-input boolean function bitwise across WIDTH-bit operands X1/X2/X3 and buffers the results in a DEPTH-entry output FIFO. Input and output use valid/ready handshakes. It sits between the stimulus-side logic and downstream consumers, and the existing driver/monitor/scoreboard environment checks it transaction by transaction.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- DEPTH, 4, output FIFO entries (power of 2, ≥2)
- TT_RESET, 8'h01, truth table loaded at reset (8'h01 = 3-input NOR, the inverter generalisation)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  load truth table this cycle
- cfg_tt  in  8  new truth table; bit index = {x3,x2,x1}
- tt_q  out  8  current truth table
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept operands
- X1, X2, X3  in  WIDTH  operands
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- Y1  out  WIDTH  result at FIFO head
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Per bit i: Y1[i] = tt[{X3[i],X2[i],X1[i]}].
- Push: occurs on in_valid && in_ready. Pushes the result computed with tt as it was before this edge.
- Pop: occurs on out_valid && out_ready. Y1 shows the head entry, and the pop advances the head.
- in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready.
  - When the FIFO is full, a same-cycle pop does not enable a push. in_ready rises the cycle after the pop.
- out_valid = (count != 0).
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks full/empty and distinguishes them.
- cfg_we:
  - tt <= cfg_tt at the edge.
  - Results already stored in the FIFO are unaffected.
  - A push in the same cycle uses the old tt.
  - cfg_we is accepted regardless of FIFO state.
- Y1 is not meaningful when out_valid=0. It is driven from the storage entry at the read pointer and is not forced to zero.
- Reset (asserted at any time, including mid-transfer):
  - Pointers and count clear, and FIFO contents are discarded.
  - tt=TT_RESET.
  - Outputs: in_ready=1, out_valid=0, count=0, tt_q=TT_RESET.
  - Storage array need not reset.
  - A handshake in the cycle reset deasserts is honoured normally.

## Timing
- Push-to-output latency is 1 cycle. Operands accepted at edge N give out_valid=1 and Y1 valid after edge N if the FIFO was empty.
- Throughput is one transaction per cycle while not full.
- cfg_we at edge N affects pushes at edge N+1 onward. tt_q updates after edge N.
- There are no combinational paths from in_valid to out_valid, or from out_ready to in_ready.

## Configuration
- INV3_PARITY_EN
  - Defined: each FIFO entry stores an extra bit par = ^Y1 computed at push. It is exposed as output Y1_par (1 bit), valid with out_valid, and reset-free like the storage.
  - Undefined: the Y1_par port and parity storage are absent. All other behaviour is identical.

## Test plan
- Reset, then push X1=8'h0F, X2=8'h33, X3=8'h55 with default TT 8'h01 -> next cycle out_valid=1, Y1=8'h80, count=1.
- cfg_tt=8'h96 (XOR3) in the same cycle as push X1=8'hFF, X2=0, X3=0, then push the same again -> first Y1=8'h00 (old NOR), second Y1=8'hFF; tt_q=8'h96.
- out_ready=0 with 5 consecutive pushes, DEPTH=4 -> in_ready drops after the 4th push, count=4, 5th held. Assert out_ready for one cycle -> pop in that cycle, no push; in_ready=1 next cycle.
- Continuous push+pop for 3×DEPTH transactions with incrementing X1 -> results in order across pointer wrap, count stays 1.
- Assert rst mid-stream with count=3 -> in_ready=1, out_valid=0, count=0, tt_q=8'h01 immediately, with no clk edge required.
- With INV3_PARITY_EN, push giving Y1=8'h07 -> Y1_par=1. Y1=8'h03 -> Y1_par=0.
